// File: rtl/flatten_pkg.sv
// flatten_pkg: shared order constants, FSM state type and index helpers for flatten_stream.
package flatten_pkg;
    localparam logic ORDER_CHW = 1'b0;
    localparam logic ORDER_HWC = 1'b1;
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
    function automatic int ceil_div(int size, int lanes);
        return (size + lanes - 1) / lanes;
    endfunction
    // HWC flat index n = pixel*C + k maps back to CHW storage offset k*H*W + pixel.
    function automatic int flat_src(int n, logic order, int c, int hw);
        return (order == ORDER_HWC) ? (n % c) * hw + n / c : n;
    endfunction
endpackage

// File: rtl/flatten_beat_mux.sv
// flatten_beat_mux: selects the LANES elements of one output beat from a held frame.
module flatten_beat_mux import flatten_pkg::*; #(
    parameter int C     = 8,
    parameter int FB    = 8,
    parameter int HW    = 36,
    parameter int LANES = 8,
    parameter int BW    = 6
) (
    input  logic [C*HW*FB-1:0] frame_i,
    input  logic [BW-1:0]      beat_i,
    input  logic               order_i,
    output logic [LANES*FB-1:0] data_o
);
    localparam int SIZE = C * HW;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int n;
        int src;
        assign n   = int'(beat_i) * LANES + l;
        assign src = flat_src(n, order_i, C, HW);
        assign data_o[l*FB +: FB] = (n < SIZE) ? frame_i[src*FB +: FB] : '0;
    end
endmodule

// File: rtl/flatten_stream.sv
// flatten_stream: captures a C x H x W frame and streams it as LANES-wide beats (CHW or HWC order).
// Define FLATTEN_STREAM_DBUF_EN to add a shadow frame so back-to-back frames stream without gaps.
module flatten_stream import flatten_pkg::*; #(
    parameter int INPUT_CHANNELS   = 8,
    parameter int FEATURE_BITWIDTH = 8,
    parameter int INPUT_WIDTH      = 6,
    parameter int INPUT_HEIGHT     = 6,
    parameter int LANES            = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    soft_rst,
    input  logic                                    data_valid,
    output logic                                    data_ready,
    input  logic                                    order_hwc,
    input  logic [INPUT_CHANNELS*INPUT_HEIGHT*INPUT_WIDTH*FEATURE_BITWIDTH-1:0] feature_map_in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LANES*FEATURE_BITWIDTH-1:0]       out_data,
    output logic                                    out_last,
    output logic                                    busy
);
    localparam int HW             = INPUT_HEIGHT * INPUT_WIDTH;
    localparam int FLATTENED_SIZE = INPUT_CHANNELS * HW;
    localparam int NUM_BEATS      = ceil_div(FLATTENED_SIZE, LANES);
    localparam int BW             = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int FW             = FLATTENED_SIZE * FEATURE_BITWIDTH;
    localparam int DW             = LANES * FEATURE_BITWIDTH;

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            order_q, order_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [DW-1:0]   out_q, out_d, mux_data;
    logic            cap, acc, last;
`ifdef FLATTEN_STREAM_DBUF_EN
    logic [FW-1:0]   sh_q, sh_d;
    logic            sh_order_q, sh_order_d, sh_full_q, sh_full_d;
    assign data_ready = !sh_full_q;
`else
    assign data_ready = (state_q == IDLE);
`endif
    assign out_valid = (state_q == STREAM);
    assign last      = (beat_q == BW'(NUM_BEATS - 1));
    assign out_last  = out_valid && last;
    assign out_data  = out_q;
    assign busy      = out_valid;
    assign acc       = out_valid && out_ready;
    assign cap       = data_valid && data_ready && !soft_rst;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        order_d = order_q;
        beat_d  = beat_q;
`ifdef FLATTEN_STREAM_DBUF_EN
        sh_d       = sh_q;
        sh_order_d = sh_order_q;
        sh_full_d  = sh_full_q;
`endif
        if (soft_rst) begin
            state_d = IDLE;
            frame_d = '0;
            beat_d  = '0;
`ifdef FLATTEN_STREAM_DBUF_EN
            sh_full_d = 1'b0;
`endif
        end else if (state_q == IDLE) begin
            if (cap) begin
                state_d = STREAM;
                frame_d = feature_map_in;
                order_d = order_hwc;
                beat_d  = '0;
            end
        end else if (acc && last) begin
            beat_d = '0;
`ifdef FLATTEN_STREAM_DBUF_EN
            if (sh_full_q) begin
                frame_d   = sh_q;
                order_d   = sh_order_q;
                sh_full_d = 1'b0;
            end else if (cap) begin
                frame_d = feature_map_in;
                order_d = order_hwc;
            end else begin
                state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
        end else begin
            beat_d = acc ? beat_q + 1'b1 : beat_q;
`ifdef FLATTEN_STREAM_DBUF_EN
            if (cap) begin
                sh_d       = feature_map_in;
                sh_order_d = order_hwc;
                sh_full_d  = 1'b1;
            end
`endif
        end
        out_d = (state_d == STREAM) ? mux_data : '0;
    end

    // Mux runs on next-state values so out_data is registered yet valid on the first beat.
    flatten_beat_mux #(
        .C(INPUT_CHANNELS), .FB(FEATURE_BITWIDTH), .HW(HW), .LANES(LANES), .BW(BW)
    ) u_mux (
        .frame_i(frame_d), .beat_i(beat_d), .order_i(order_d), .data_o(mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            order_q <= ORDER_CHW;
            beat_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            order_q <= order_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
        end
    end

`ifdef FLATTEN_STREAM_DBUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= '0;
            sh_order_q <= ORDER_CHW;
            sh_full_q  <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            sh_order_q <= sh_order_d;
            sh_full_q  <= sh_full_d;
        end
    end
`endif
endmodule

// File: tb/tb_flatten_stream.sv
// tb_flatten_stream: directed checks of flatten_stream with LANES=8 and LANES=5 instances.
module tb_flatten_stream;
    logic          clk = 1'b0, rst_n = 1'b0, soft_rst = 1'b0;
    logic          dv0 = 1'b0, dv1 = 1'b0, ord = 1'b0, rdy = 1'b1;
    logic [2303:0] fm;
    logic          dr0, ov0, ol0, busy0, dr1, ov1, ol1, busy1;
    logic [63:0]   od0;
    logic [39:0]   od1;
    int            total = 0, bad = 0;

    always #5 clk = ~clk;

    flatten_stream u0 (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .data_valid(dv0), .data_ready(dr0),
        .order_hwc(ord), .feature_map_in(fm), .out_valid(ov0), .out_ready(rdy),
        .out_data(od0), .out_last(ol0), .busy(busy0)
    );
    flatten_stream #(.LANES(5)) u1 (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .data_valid(dv1), .data_ready(dr1),
        .order_hwc(ord), .feature_map_in(fm), .out_valid(ov1), .out_ready(rdy),
        .out_data(od1), .out_last(ol1), .busy(busy1)
    );

    function automatic logic [63:0] exp_beat(int lanes, int b, bit hwc);
        logic [63:0] r;
        int n, src;
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            n = b * lanes + l;
            src = hwc ? (n % 8) * 36 + n / 8 : n;
            if (n < 288) r[l*8 +: 8] = 8'(src % 256);
        end
        return r;
    endfunction

    task automatic capture0(bit hwc);
        @(negedge clk);
        ord = hwc;
        dv0 = 1'b1;
        @(negedge clk);
        dv0 = 1'b0;
        total++;
        if (ov0 !== 1'b1) begin
            bad++;
            $display("FAIL capture_latency out_valid=%b want 1", ov0);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({ov0, ol0, busy0, dr0} !== 4'b0001 || od0 !== 64'd0) begin
            bad++;
            $display("FAIL reset v/l/busy/ready=%b data=%h want 0001 data 0", {ov0, ol0, busy0, dr0}, od0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_chw();
        rdy = 1'b1;
        capture0(1'b0);
        for (int b = 0; b < 36; b++) begin
            total++;
            if (ov0 !== 1'b1 || od0 !== exp_beat(8, b, 1'b0) || ol0 !== (b == 35)) begin
                bad++;
                $display("FAIL chw_beat%0d v=%b data=%h last=%b want data %h", b, ov0, od0, ol0, exp_beat(8, b, 1'b0));
            end
            if (b == 0) begin
                total++;
                if (od0 !== 64'h0706050403020100) begin
                    bad++;
                    $display("FAIL chw_beat0_const data=%h want 0706050403020100", od0);
                end
            end
            if (b == 35) begin
                total++;
                if (od0 !== 64'h1f1e1d1c1b1a1918 || ol0 !== 1'b1) begin
                    bad++;
                    $display("FAIL chw_beat35_const data=%h last=%b want 1f1e1d1c1b1a1918 1", od0, ol0);
                end
            end
            @(negedge clk);
        end
        total++;
        if (ov0 !== 1'b0 || dr0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL chw_end v=%b ready=%b busy=%b want 0 1 0", ov0, dr0, busy0);
        end
    endtask

    task automatic test_hwc();
        rdy = 1'b1;
        capture0(1'b1);
        total++;
        if (od0 !== 64'hfcd8b4906c482400) begin
            bad++;
            $display("FAIL hwc_beat0 data=%h want fcd8b4906c482400", od0);
        end
        @(negedge clk);
        total++;
        if (od0 !== 64'hfdd9b5916d492501) begin
            bad++;
            $display("FAIL hwc_beat1 data=%h want fdd9b5916d492501", od0);
        end
        for (int b = 2; b < 36; b++) begin
            @(negedge clk);
            total++;
            if (od0 !== exp_beat(8, b, 1'b1) || ol0 !== (b == 35)) begin
                bad++;
                $display("FAIL hwc_beat%0d data=%h last=%b want %h", b, od0, ol0, exp_beat(8, b, 1'b1));
            end
        end
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0) begin
            bad++;
            $display("FAIL hwc_end out_valid=%b want 0", ov0);
        end
    endtask

    task automatic test_lanes5();
        rdy = 1'b1;
        ord = 1'b0;
        @(negedge clk);
        dv1 = 1'b1;
        @(negedge clk);
        dv1 = 1'b0;
        for (int b = 0; b < 58; b++) begin
            total++;
            if (ov1 !== 1'b1 || od1 !== exp_beat(5, b, 1'b0) || ol1 !== (b == 57)) begin
                bad++;
                $display("FAIL l5_beat%0d v=%b data=%h last=%b want %h", b, ov1, od1, ol1, exp_beat(5, b, 1'b0));
            end
            if (b == 57) begin
                total++;
                if (od1 !== 40'h00001f1e1d) begin
                    bad++;
                    $display("FAIL l5_last_const data=%h want 00001f1e1d", od1);
                end
            end
            @(negedge clk);
        end
        total++;
        if (ov1 !== 1'b0) begin
            bad++;
            $display("FAIL l5_end out_valid=%b want 0", ov1);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int idx, cyc;
        pat = 4'b1001;
        idx = 0;
        cyc = 0;
        capture0(1'b0);
        while (idx < 36 && cyc < 400) begin
            rdy = pat[cyc % 4];
            total++;
            if (ov0 !== 1'b1 || od0 !== exp_beat(8, idx, 1'b0) || ol0 !== (idx == 35)) begin
                bad++;
                $display("FAIL bp_beat%0d cyc%0d v=%b data=%h last=%b want %h", idx, cyc, ov0, od0, ol0, exp_beat(8, idx, 1'b0));
            end
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        rdy = 1'b1;
        total++;
        if (idx != 36 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL bp_count beats=%0d v=%b want 36 0", idx, ov0);
        end
    endtask

    task automatic test_soft_rst();
        rdy = 1'b1;
        capture0(1'b0);
        repeat (10) @(negedge clk);
        total++;
        if (od0 !== exp_beat(8, 10, 1'b0)) begin
            bad++;
            $display("FAIL srst_beat10 data=%h want %h", od0, exp_beat(8, 10, 1'b0));
        end
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        total++;
        if (ov0 !== 1'b0 || od0 !== 64'd0 || dr0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL srst_idle v=%b data=%h ready=%b busy=%b want 0 0 1 0", ov0, od0, dr0, busy0);
        end
        capture0(1'b0);
        total++;
        if (od0 !== 64'h0706050403020100 || ol0 !== 1'b0) begin
            bad++;
            $display("FAIL srst_restart data=%h last=%b want 0706050403020100 0", od0, ol0);
        end
        repeat (36) @(negedge clk);
        total++;
        if (ov0 !== 1'b0) begin
            bad++;
            $display("FAIL srst_drain out_valid=%b want 0", ov0);
        end
    endtask

`ifdef FLATTEN_STREAM_DBUF_EN
    task automatic test_back_to_back();
        int caps, cap3_at;
        caps = 0;
        cap3_at = -1;
        rdy = 1'b1;
        ord = 1'b0;
        @(negedge clk);
        dv0 = 1'b1;
        if (dr0) caps++;
        @(negedge clk);
        for (int c = 0; c < 108; c++) begin
            if (dv0 && dr0) begin
                caps++;
                if (caps == 3) cap3_at = c;
            end
            total++;
            if (ov0 !== 1'b1 || od0 !== exp_beat(8, c % 36, 1'b0) || ol0 !== (c % 36 == 35)) begin
                bad++;
                $display("FAIL dbuf_beat%0d v=%b data=%h last=%b want %h", c, ov0, od0, ol0, exp_beat(8, c % 36, 1'b0));
            end
            if (c == 5) begin
                total++;
                if (dr0 !== 1'b0) begin
                    bad++;
                    $display("FAIL dbuf_ready_full ready=%b want 0", dr0);
                end
            end
            @(negedge clk);
            if (caps == 3) dv0 = 1'b0;
        end
        total++;
        if (ov0 !== 1'b0 || caps != 3 || cap3_at != 36) begin
            bad++;
            $display("FAIL dbuf_end v=%b captures=%0d third_at=%0d want 0 3 36", ov0, caps, cap3_at);
        end
    endtask
`endif

    initial begin
        for (int m = 0; m < 288; m++) fm[m*8 +: 8] = 8'(m % 256);
        test_reset();
        test_chw();
        test_hwc();
        test_lanes5();
        test_backpressure();
        test_soft_rst();
`ifdef FLATTEN_STREAM_DBUF_EN
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
